// File: rtl/inv_pkg.sv
// inv_pkg: shared types, mode constants and counter sizing for the Kaliski
// modular inverter (kaliski_inverter and its mod_halve_double unit).
package inv_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_FIX  = 3'd2,
        ST_PH2  = 3'd3,
        ST_DONE = 3'd4
    } inv_state_e;

    // Result flavour: plain inverse a^-1 mod p, or Montgomery inverse.
    localparam logic MODE_PLAIN = 1'b0;
    localparam logic MODE_MONT  = 1'b1;

    // Width of the step/operation counters; must hold values up to 2*w.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/mod_halve_double.sv
// mod_halve_double: combinational single-step modular correction used by the
// second inverter phase. Assumes x_i < p_i and p_i odd.
//   x_i   in  WIDTH  current value
//   p_i   in  WIDTH  modulus
//   op_i  in  1      0 = halve (x/2 mod p), 1 = double (2x mod p)
//   x_c_o out WIDTH  updated value (combinational)
module mod_halve_double
    import inv_pkg::*;
#(
    parameter int unsigned WIDTH = 256
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic             op_i,
    output logic [WIDTH-1:0] x_c_o
);

    logic [WIDTH:0] x_ext;
    logic [WIDTH:0] p_ext;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] half_sum;

    assign x_ext = {1'b0, x_i};
    assign p_ext = {1'b0, p_i};
    assign dbl   = {x_i, 1'b0};

    // Odd values get p added first so the shift stays exact modulo p.
    assign half_sum = x_i[0] ? (x_ext + p_ext) : x_ext;

    always_comb begin
        x_c_o = '0;
        if (op_i == MODE_MONT) begin
            x_c_o = WIDTH'((dbl >= p_ext) ? (dbl - p_ext) : dbl);
        end else begin
            x_c_o = WIDTH'(half_sum >> 1);
        end
    end

endmodule

// File: rtl/kaliski_inverter.sv
// kaliski_inverter: sequential modular inverter based on Kaliski's almost
// inverse. Phase 1 produces a^-1 * 2^k mod p; phase 2 halves k times (plain
// inverse) or doubles 2*WIDTH-k times (Montgomery inverse).
//   clk      in  1      clock, rising edge
//   rst      in  1      asynchronous active-high reset
//   start    in  1      request pulse, honoured only when idle
//   a        in  WIDTH  operand (a*R mod p for Montgomery mode, R = 2^WIDTH)
//   p        in  WIDTH  modulus, odd and > 2
//   mode_vld in  1      1 = use mode, 0 = use DEF_MODE
//   mode     in  1      per-request mode
//   c        out WIDTH  result, held until the next completion
//   busy     out 1      operation in flight
//   done     out 1      one-cycle completion pulse
//   err      out 1      qualified by done; no inverse exists (c = 0)
module kaliski_inverter
    import inv_pkg::*;
#(
    parameter int unsigned WIDTH    = 256,
    parameter logic        DEF_MODE = MODE_MONT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    input  logic             mode_vld,
    input  logic             mode,
    output logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned KW = cnt_width(WIDTH);
    localparam int unsigned RW = WIDTH + 1;
    localparam logic [KW-1:0] K_MAX = KW'(2 * WIDTH);

    inv_state_e       state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [RW-1:0]    r_q, r_d;
    logic [RW-1:0]    s_q, s_d;
    logic [KW-1:0]    k_q, k_d;
    logic [KW-1:0]    n_q, n_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             fail_q, fail_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [RW-1:0]    p_ext;
    logic [RW-1:0]    r_red;
    logic [WIDTH-1:0] hd_x;
    logic             bad_req_c;

    assign p_ext = {1'b0, p_q};

    // Requests that can be rejected without running the algorithm.
    assign bad_req_c = (a == '0) || (a >= p) || !p[0] || (p < WIDTH'(3));

    // Phase-2 modular halve/double step on the working value.
    mod_halve_double #(
        .WIDTH (WIDTH)
    ) u_halve_double (
        .x_i   (x_q),
        .p_i   (p_q),
        .op_i  (mode_q),
        .x_c_o (hd_x)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        mode_d  = mode_q;
        u_d     = u_q;
        v_d     = v_q;
        r_d     = r_q;
        s_d     = s_q;
        k_d     = k_q;
        n_d     = n_q;
        x_d     = x_q;
        fail_d  = fail_q;
        c_d     = c_q;
        err_d   = err_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        r_red   = (r_q >= p_ext) ? (r_q - p_ext) : r_q;

        unique case (state_q)
            ST_IDLE: begin
                // The cycle that shows done is still the tail of the last run.
                if (start && !done_q) begin
                    p_d     = p;
                    mode_d  = mode_vld ? mode : DEF_MODE;
                    u_d     = p;
                    v_d     = a;
                    r_d     = '0;
                    s_d     = RW'(1);
                    k_d     = '0;
                    n_d     = '0;
                    x_d     = '0;
                    fail_d  = bad_req_c;
                    state_d = bad_req_c ? ST_DONE : ST_PH1;
                end
            end

            ST_PH1: begin
                k_d = k_q + KW'(1);
                if (!u_q[0]) begin
                    u_d = u_q >> 1;
                    s_d = s_q << 1;
                end else if (!v_q[0]) begin
                    v_d = v_q >> 1;
                    r_d = r_q << 1;
                end else if (u_q > v_q) begin
                    u_d = (u_q - v_q) >> 1;
                    r_d = r_q + s_q;
                    s_d = s_q << 1;
                end else begin
                    v_d = (v_q - u_q) >> 1;
                    s_d = s_q + r_q;
                    r_d = r_q << 1;
                end
                // Valid inputs always finish within 2*WIDTH steps.
                if (v_d == '0) begin
                    state_d = ST_FIX;
                end else if (k_d == K_MAX) begin
                    fail_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_FIX: begin
                // u holds gcd(a, p) here.
                if (u_q != WIDTH'(1)) begin
                    fail_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    x_d     = WIDTH'(p_ext - r_red);
                    n_d     = (mode_q == MODE_MONT) ? (K_MAX - k_q) : k_q;
                    state_d = ST_PH2;
                end
            end

            ST_PH2: begin
                if (n_q != '0) begin
                    x_d = hd_x;
                    n_d = n_q - KW'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                c_d     = fail_q ? '0 : x_q;
                err_d   = fail_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            mode_q  <= MODE_PLAIN;
            u_q     <= '0;
            v_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            x_q     <= '0;
            fail_q  <= 1'b0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            u_q     <= u_d;
            v_q     <= v_d;
            r_q     <= r_d;
            s_q     <= s_d;
            k_q     <= k_d;
            n_q     <= n_d;
            x_q     <= x_d;
            fail_q  <= fail_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_kaliski_inverter.sv
// Scoreboard bench for kaliski_inverter at WIDTH=8: requests push expected
// results computed by brute-force modular arithmetic; a monitor pops and
// compares on every done pulse.
module tb_kaliski_inverter;

    localparam int unsigned W        = 8;
    localparam bit          DEF_MODE = 1'b1;
    localparam int unsigned R2       = 1 << (2 * W);
    localparam int          MAX_LAT  = 4 * W + 3;

    typedef struct {
        bit           err;
        logic [W-1:0] c;
        bit           exact;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] p;
    logic         mode_vld;
    logic         mode;
    logic [W-1:0] c;
    logic         busy;
    logic         done;
    logic         err;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    exp_t sb_q[$];

    kaliski_inverter #(
        .WIDTH    (W),
        .DEF_MODE (DEF_MODE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .p        (p),
        .mode_vld (mode_vld),
        .mode     (mode),
        .c        (c),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain inverse by search; Montgomery result is inv(a_in)*R^2.
    function automatic exp_t model(input int unsigned av, input int unsigned pv,
                                   input bit mv, input bit mb);
        exp_t        e;
        int unsigned inv;
        bit          m;
        m       = mv ? mb : DEF_MODE;
        e.err   = 1'b0;
        e.c     = '0;
        e.exact = 1'b0;
        e.acc   = 0;
        if (av == 0 || av >= pv || (pv % 2) == 0 || pv < 3) begin
            e.err   = 1'b1;
            e.exact = 1'b1;
            return e;
        end
        inv = 0;
        for (int unsigned i = 1; i < pv; i++) begin
            if ((av * i) % pv == 1) begin
                inv = i;
                break;
            end
        end
        if (inv == 0) begin
            e.err = 1'b1;
            return e;
        end
        e.c = m ? W'((inv * (R2 % pv)) % pv) : W'(inv);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   lat;
        if (!rst && done) begin
            done_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done got c=%0d err=%0b want no done", c, err);
            end else begin
                e   = sb_q.pop_front();
                lat = cyc - e.acc;
                checks++;
                if (err !== e.err) begin
                    failures++;
                    $display("FAIL err_flag got=%0b want=%0b", err, e.err);
                end
                checks++;
                if (c !== e.c) begin
                    failures++;
                    $display("FAIL result_c got=%0d want=%0d", c, e.c);
                end
                checks++;
                if (e.exact ? (lat != 1) : (lat < 3 || lat > MAX_LAT)) begin
                    failures++;
                    $display("FAIL latency got=%0d want=%s", lat,
                             e.exact ? "1" : "3..35");
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout got busy=%0b want 0", busy);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout got no done want done within 200 cycles");
        end
    endtask

    // Issue one request; inputs are scrambled right after acceptance.
    task automatic issue(input int unsigned av, input int unsigned pv,
                         input bit mv, input bit mb, input bit track);
        exp_t e;
        wait_idle();
        e        = model(av, pv, mv, mb);
        e.acc    = cyc + 1;
        a        = W'(av);
        p        = W'(pv);
        mode_vld = mv;
        mode     = mb;
        start    = 1'b1;
        if (track) sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_accept got=%0b want=1", busy);
        end
        a        = W'($urandom);
        p        = W'($urandom);
        mode     = ~mode;
        mode_vld = ~mode_vld;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (c !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL %s got c=%0d busy=%0b done=%0b err=%0b want all 0",
                     tag, c, busy, done, err);
        end
    endtask

    task automatic check_no_new_done(input string tag, input int cycles);
        int ref_cnt;
        ref_cnt = done_cnt;
        repeat (cycles) @(negedge clk);
        checks++;
        if (done_cnt != ref_cnt) begin
            failures++;
            $display("FAIL %s got %0d extra done pulses want 0", tag, done_cnt - ref_cnt);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          cnt0;
        int unsigned pv;
        int unsigned av;
        int unsigned sel;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        p        = '0;
        mode_vld = 1'b0;
        mode     = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // Directed cases.
        issue(3, 7, 1'b1, 1'b0, 1'b1);
        wait_done();
        issue(5, 7, 1'b1, 1'b1, 1'b1);
        wait_done();
        issue(5, 7, 1'b0, 1'b0, 1'b1);
        wait_done();
        issue(5, 15, 1'b1, 1'b0, 1'b1);
        wait_done();
        issue(0, 251, 1'b1, 1'b0, 1'b1);
        wait_done();
        issue(9, 7, 1'b1, 1'b0, 1'b1);
        wait_done();
        issue(3, 8, 1'b1, 1'b1, 1'b1);
        wait_done();
        issue(1, 3, 1'b1, 1'b1, 1'b1);
        wait_done();
        issue(254, 255, 1'b1, 1'b0, 1'b1);
        wait_done();

        // Start while busy is dropped; only one done may follow.
        @(negedge clk);
        cnt0 = done_cnt;
        issue(1, 251, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        a     = W'(77);
        p     = W'(101);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        checks++;
        if (done_cnt != cnt0 + 1) begin
            failures++;
            $display("FAIL busy_start_ignored got %0d dones want 1", done_cnt - cnt0);
        end
        check_no_new_done("busy_start_late_done", 60);

        // Start in the same cycle as done is dropped.
        issue(3, 7, 1'b1, 1'b0, 1'b1);
        wait_done();
        a        = W'(3);
        p        = W'(7);
        mode_vld = 1'b1;
        mode     = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_on_done got busy=%0b want=0", busy);
        end
        check_no_new_done("start_on_done", 40);

        // Reset during phase 1 abandons the run.
        issue(1, 251, 1'b1, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        issue(200, 251, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid_run");
        @(negedge clk);
        rst = 1'b0;
        check_no_new_done("reset_no_done", 60);
        issue(3, 7, 1'b1, 1'b0, 1'b1);
        wait_done();

        // Randomized requests.
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      pv = $urandom_range(0, 127) * 2;
            else if (sel == 1) pv = 1;
            else               pv = $urandom_range(1, 127) * 2 + 1;
            sel = $urandom_range(0, 9);
            if (sel == 0)      av = 0;
            else if (sel == 1) av = $urandom_range(pv > 255 ? 255 : pv, 255);
            else if (pv < 2)   av = $urandom_range(0, 255);
            else               av = $urandom_range(1, pv - 1);
            issue(av, pv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            wait_done();
        end

        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
